// File: rtl/voter_pkg.sv
// Shared constants for the four-seat voter: verdict encodings and default thresholds.
package voter_pkg;

  localparam int unsigned N_SEATS_DEF  = 32'd4;
  localparam int unsigned PASS_MIN_DEF = 32'd3;
  localparam int unsigned TIE_CNT_DEF  = 32'd2;

  localparam logic [2:0] VERDICT_NONE = 3'b000;
  localparam logic [2:0] VERDICT_PASS = 3'b001;
  localparam logic [2:0] VERDICT_TIE  = 3'b010;
  localparam logic [2:0] VERDICT_FAIL = 3'b100;

endpackage

// File: rtl/popcount4.sv
// Combinational aye counter: number of set bits in a 4-bit ballot, 0..4.
module popcount4 (
  input  logic [3:0] ballot,
  output logic [2:0] cnt
);

  assign cnt = {2'b00, ballot[0]} + {2'b00, ballot[1]}
             + {2'b00, ballot[2]} + {2'b00, ballot[3]};

endmodule

// File: rtl/voter_if.sv
// Four-seat vote decision: counts ayes each cycle and registers a one-hot
// pass/tie/fail verdict; reset forces the "no verdict" code.
module voter_if
  import voter_pkg::*;
#(
  parameter int unsigned N_SEATS  = N_SEATS_DEF,
  parameter int unsigned PASS_MIN = PASS_MIN_DEF,
  parameter int unsigned TIE_CNT  = TIE_CNT_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_SEATS-1:0] I,
  output logic [3:1]         O
);

  logic [2:0] cnt_s;
  logic [2:0] verdict_s;
  logic [2:0] verdict_r;

  popcount4 u_popcount4 (
    .ballot (I),
    .cnt    (cnt_s)
  );

  // Decode the aye count; pass wins over tie if the thresholds ever overlap.
  always_comb begin
    verdict_s = VERDICT_FAIL;
    if ({29'd0, cnt_s} >= PASS_MIN) begin
      verdict_s = VERDICT_PASS;
    end else if ({29'd0, cnt_s} == TIE_CNT) begin
      verdict_s = VERDICT_TIE;
    end else begin
      verdict_s = VERDICT_FAIL;
    end
  end

  // Output register; reset drops the in-flight sample and shows no verdict.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      verdict_r <= VERDICT_NONE;
    end else begin
      verdict_r <= verdict_s;
    end
  end

  assign O = verdict_r;

endmodule

// File: tb/tb_voter_if.sv
// Self-checking bench for voter_if: directed scenarios plus random ballots
// against a count-based reference model.
module tb_voter_if;

  logic       clk;
  logic       rst;
  logic [3:0] I;
  logic [3:1] O;

  int n_checks;
  int n_fail;

  voter_if dut (
    .clk (clk),
    .rst (rst),
    .I   (I),
    .O   (O)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] ref_verdict(input logic [3:0] v);
    int ayes;
    ayes = 0;
    for (int k = 0; k < 4; k++) ayes += (v[k] === 1'b1) ? 1 : 0;
    if (ayes >= 3)      return 3'b001;
    else if (ayes == 2) return 3'b010;
    else                return 3'b100;
  endfunction

  task automatic check_eq(input string tag, input logic [2:0] got, input logic [2:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_onehot(input string tag);
    logic [2:0] ones;
    ones = 3'($countones(O));
    check_eq(tag, ones, 3'd1);
  endtask

  // Drive a ballot between edges, then sample just after the next rising edge.
  task automatic step(input logic [3:0] v, input string tag);
    @(negedge clk);
    I = v;
    @(posedge clk);
    #1;
    check_eq(tag, O, ref_verdict(v));
    check_onehot({tag, "_onehot"});
  endtask

  initial begin
    logic [2:0] prev;
    logic [3:0] v;
    n_checks = 0;
    n_fail   = 0;
    I   = 4'b1111;
    rst = 1'b0;

    // Reset applies without a clock edge.
    #2;
    rst = 1'b1;
    #1;
    check_eq("reset_async", O, 3'b000);
    repeat (3) begin
      @(posedge clk);
      #1;
      check_eq("reset_hold", O, 3'b000);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("reset_release_no_edge", O, 3'b000);
    @(posedge clk);
    #1;
    check_eq("reset_first_edge", O, 3'b001);

    // Exhaustive sweep, covers seat symmetry of every two-bit pattern.
    for (int i = 0; i < 16; i++) step(4'(i), "sweep");

    // One-cycle latency.
    step(4'b0000, "lat_pre");
    @(negedge clk);
    I = 4'b0111;
    #1;
    check_eq("lat_before_edge", O, 3'b100);
    @(posedge clk);
    #1;
    check_eq("lat_after_edge", O, 3'b001);

    // Mid-stream reset while toggling 0011 <-> 1110.
    step(4'b0011, "toggle_a");
    step(4'b1110, "toggle_b");
    @(negedge clk);
    I = 4'b0011;
    #2;
    rst = 1'b1;
    #1;
    check_eq("mid_reset_async", O, 3'b000);
    @(posedge clk);
    #1;
    check_eq("mid_reset_hold", O, 3'b000);
    @(negedge clk);
    rst = 1'b0;
    I = 4'b1110;
    @(posedge clk);
    #1;
    check_eq("mid_reset_resume", O, 3'b001);
    step(4'b0011, "resume_toggle");

    // Hold a constant ballot: verdict must not move.
    step(4'b1000, "hold_first");
    prev = O;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      check_eq("hold_value", O, 3'b100);
      check_eq("hold_stable", O, prev);
      prev = O;
    end

    // Random ballots against the reference model.
    for (int r = 0; r < 200; r++) begin
      v = 4'($urandom_range(0, 15));
      step(v, "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
